// File: rtl/cmp_run_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmp_run_monitor_if                                        |
// | Brief    : Dump-side bus of the CMP run monitor: the shared dmem     |
// |            read port and the valid/ready dump word stream.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface cmp_run_monitor_if #(
  parameter int NODE_W = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  // Shared data-memory read port (data returns one cycle after mem_rd_en)
  logic              mem_rd_en;
  logic [NODE_W-1:0] mem_node;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;

  // Dump word stream
  logic              dump_valid;
  logic              dump_ready;
  logic [NODE_W-1:0] dump_node;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  // Monitor side
  modport master (
    output mem_rd_en, mem_node, mem_addr,
    input  mem_rd_data,
    output dump_valid, dump_node, dump_addr, dump_data,
    input  dump_ready
  );

  // Harness side (dmem mux and dump sink)
  modport slave (
    input  mem_rd_en, mem_node, mem_addr,
    output mem_rd_data,
    input  dump_valid, dump_node, dump_addr, dump_data,
    output dump_ready
  );
endinterface
`default_nettype wire

// File: rtl/cmp_run_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmp_run_monitor                                           |
// | Brief    : Run controller for an N-node CMP harness. Detects program |
// |            completion (all nodes fetching the zero NOP) or a cycle   |
// |            budget timeout, drains the pipelines, then streams every  |
// |            node's data memory out over a valid/ready interface.      |
// | Options  : `define CMP_MON_STICKY_EN makes the per-node completion   |
// |            mask sticky for the duration of a run.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cmp_run_monitor #(
  parameter int NUM_NODES    = 4,
  parameter int INST_W       = 32,
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 8,
  parameter int CYC_W        = 32,
  parameter int MAX_CYCLES   = 5000,
  parameter int DRAIN_CYCLES = 5,
  parameter int DUMP_DEPTH   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_run_en,
  input  logic [NUM_NODES*INST_W-1:0] i_inst_in,
  output logic [CYC_W-1:0]            o_cycle_count,
  output logic                        o_running,
  output logic                        o_halt,
  output logic                        o_timeout,
  output logic                        o_done,
  output logic [NUM_NODES-1:0]        o_done_mask,
  cmp_run_monitor_if.master           mon_bus
);

  localparam int c_node_w  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int c_drain_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CYC_W-1:0]     c_last_cycle = CYC_W'(MAX_CYCLES - 1);
  localparam logic [c_node_w-1:0]  c_last_node  = c_node_w'(NUM_NODES - 1);
  localparam logic [ADDR_W-1:0]    c_last_addr  = ADDR_W'(DUMP_DEPTH - 1);
  localparam logic [c_drain_w-1:0] c_last_drain = c_drain_w'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_DRAIN    = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_CAP = 3'd4,
    S_DUMP_OUT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [CYC_W-1:0]      r_cycle_count;
  logic                  r_timeout;
  logic [NUM_NODES-1:0]  r_done_mask;
  logic [c_drain_w-1:0]  r_drain_cnt;
  logic [c_node_w-1:0]   r_node;
  logic [ADDR_W-1:0]     r_addr;
  logic [c_node_w-1:0]   r_dump_node;
  logic [ADDR_W-1:0]     r_dump_addr;
  logic [DATA_W-1:0]     r_dump_data;

  logic [NUM_NODES-1:0]  w_node_zero;
  logic [NUM_NODES-1:0]  w_mask_eff;
  logic                  w_nop_term;
  logic                  w_budget_term;
  logic                  w_last_word;

  // Per-node terminating-NOP detect on the fetched instruction
  for (genvar k = 0; k < NUM_NODES; k++) begin : g_zero_det
    assign w_node_zero[k] = (i_inst_in[k*INST_W +: INST_W] == '0);
  end

`ifdef CMP_MON_STICKY_EN
  // A node stays complete once it has fetched the NOP during this run
  assign w_mask_eff = r_done_mask | w_node_zero;
`else
  assign w_mask_eff = w_node_zero;
`endif

  // NOP termination takes priority over the budget when both coincide
  assign w_nop_term    = &w_mask_eff;
  assign w_budget_term = (r_cycle_count == c_last_cycle);
  assign w_last_word   = (r_node == c_last_node) && (r_addr == c_last_addr);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; run_en only matters in IDLE, RUN and DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_run_en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!i_run_en)                       w_state_nxt = S_IDLE;
        else if (w_nop_term || w_budget_term) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt == c_last_drain) w_state_nxt = S_DUMP_RD;
      end
      S_DUMP_RD: begin
        w_state_nxt = S_DUMP_CAP;
      end
      S_DUMP_CAP: begin
        w_state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (mon_bus.dump_ready) w_state_nxt = w_last_word ? S_DONE : S_DUMP_RD;
      end
      S_DONE: begin
        if (!i_run_en) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Run counters, completion status, dump index and captured dump word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
      r_done_mask   <= '0;
      r_drain_cnt   <= '0;
      r_node        <= '0;
      r_addr        <= '0;
      r_dump_node   <= '0;
      r_dump_addr   <= '0;
      r_dump_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run_en) begin
            r_cycle_count <= '0;
            r_done_mask   <= '0;
            r_timeout     <= 1'b0;
          end
        end
        S_RUN: begin
          // Dropping run_en aborts to IDLE with everything held
          if (i_run_en) begin
            if (r_cycle_count != '1) begin
              r_cycle_count <= r_cycle_count + CYC_W'(1);
            end
            r_done_mask <= w_mask_eff;
            if (!w_nop_term && w_budget_term) begin
              r_timeout <= 1'b1;
            end
            if (w_nop_term || w_budget_term) begin
              r_drain_cnt <= '0;
              r_node      <= '0;
              r_addr      <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt != c_last_drain) begin
            r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
          end
        end
        S_DUMP_CAP: begin
          r_dump_data <= mon_bus.mem_rd_data;
          r_dump_node <= r_node;
          r_dump_addr <= r_addr;
        end
        S_DUMP_OUT: begin
          // Address-major, node-minor walk
          if (mon_bus.dump_ready && !w_last_word) begin
            if (r_node == c_last_node) begin
              r_node <= '0;
              r_addr <= r_addr + ADDR_W'(1);
            end else begin
              r_node <= r_node + c_node_w'(1);
            end
          end
        end
        S_DONE: begin
          if (!i_run_en) begin
            r_done_mask <= '0;
            r_timeout   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_cycle_count      = r_cycle_count;
  assign o_running          = (r_state == S_RUN);
  assign o_halt             = (r_state == S_DUMP_RD) || (r_state == S_DUMP_CAP) ||
                              (r_state == S_DUMP_OUT) || (r_state == S_DONE);
  assign o_timeout          = r_timeout;
  assign o_done             = (r_state == S_DONE);
  assign o_done_mask        = r_done_mask;

  assign mon_bus.mem_rd_en  = (r_state == S_DUMP_RD);
  assign mon_bus.mem_node   = r_node;
  assign mon_bus.mem_addr   = r_addr;
  assign mon_bus.dump_valid = (r_state == S_DUMP_OUT);
  assign mon_bus.dump_node  = r_dump_node;
  assign mon_bus.dump_addr  = r_dump_addr;
  assign mon_bus.dump_data  = r_dump_data;

endmodule
`default_nettype wire
